// File: rtl/stream_cipher_pkg.sv
// stream_cipher_pkg: shared state encoding, default keystream constants and the Galois LFSR step.
package stream_cipher_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    localparam logic [15:0] SEED_DEF = 16'hACE1;
    localparam logic [15:0] TAPS_DEF = 16'hB400;
    // Generic up to 32 bits; callers zero-extend and truncate to their own width.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] taps);
        return (s >> 1) ^ (s[0] ? taps : 32'd0);
    endfunction
endpackage

// File: rtl/lfsr_keystream.sv
// lfsr_keystream: Galois LFSR keystream source; a zero load value falls back to SEED.
module lfsr_keystream
    import stream_cipher_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(SEED_DEF),
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(TAPS_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic              ks_bit
);
    logic [LFSR_W-1:0] lfsr;
    assign ks_bit = lfsr[0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= SEED;
        else if (load) lfsr <= (load_val == '0) ? SEED : load_val;
        else if (step) lfsr <= LFSR_W'(lfsr_step(32'(lfsr), 32'(TAPS)));
    end
endmodule

// File: rtl/stream_cipher_tx.sv
// stream_cipher_tx: bit-serial LFSR stream-cipher transmitter, LSB-first framed output.
// Optional trailing even-parity bit when STREAM_CIPHER_PARITY_EN is defined.
module stream_cipher_tx
    import stream_cipher_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(SEED_DEF),
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(TAPS_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_val,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              tx_valid,
    output logic              tx_bit,
    output logic              tx_sof,
    output logic              tx_eof,
    output logic              busy
);
    localparam int            CW   = DATA_W > 1 ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    state_t            state, state_nx;
    logic [DATA_W-1:0] shreg;
    logic [CW-1:0]     cnt;
    logic              accept, more, step, ks_bit, c_bit, par_out, par;
    assign in_ready = state == IDLE && !seed_load;
    assign busy     = state != IDLE;
    assign accept   = in_valid && in_ready;
    assign more     = state == SHIFT && cnt != LAST;
    assign step     = accept || more;
    // Outputs are registered, so bit 0 is computed straight from in_data at the acceptance edge.
    assign c_bit    = (accept ? in_data[0] : shreg[0]) ^ ks_bit;
`ifdef STREAM_CIPHER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    assign par_out = state == SHIFT && !more;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par <= 1'b0;
        else if (accept) par <= c_bit;
        else if (more) par <= par ^ c_bit;
    end
`else
    localparam bit PAR_EN = 1'b0;
    assign par_out = 1'b0;
    assign par     = 1'b0;
`endif
    lfsr_keystream #(.LFSR_W(LFSR_W), .SEED(SEED), .TAPS(TAPS)) u_lfsr (
        .clk(clk), .rst_n(rst_n), .load(seed_load && state == IDLE),
        .load_val(seed_val), .step(step), .ks_bit(ks_bit)
    );
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? SHIFT : IDLE;
            SHIFT:   state_nx = more ? SHIFT : (PAR_EN ? PARITY : IDLE);
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            tx_valid <= 1'b0;
            tx_bit   <= 1'b0;
            tx_sof   <= 1'b0;
            tx_eof   <= 1'b0;
        end else begin
            state    <= state_nx;
            tx_valid <= step || par_out;
            tx_bit   <= step ? c_bit : (par_out && par);
            tx_sof   <= accept;
            tx_eof   <= par_out || (!PAR_EN && more && cnt == CW'(DATA_W - 2));
            if (accept) begin
                shreg <= in_data >> 1;
                cnt   <= '0;
            end else if (more) begin
                shreg <= shreg >> 1;
                cnt   <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stream_cipher_tx.sv
// tb_stream_cipher_tx: scoreboard bench for stream_cipher_tx (honours STREAM_CIPHER_PARITY_EN).
module tb_stream_cipher_tx;
`ifdef STREAM_CIPHER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = PAR ? 9 : 8;
    typedef struct packed {logic b; logic sof; logic eof;} exp_t;

    logic clk = 1'b0, rst_n = 1'b0, seed_load = 1'b0, in_valid = 1'b0;
    logic [15:0] seed_val = '0;
    logic [7:0] in_data = '0;
    logic in_ready, tx_valid, tx_bit, tx_sof, tx_eof, busy;

    exp_t q[$];
    int checks = 0, failures = 0;
    int cyc = 0, acc_cnt = 0, acc_cyc = 0, sof_cyc = 0, eof_cyc = 0, gap = 0, idx = 0;
    logic [7:0] rx_byte = '0;
    logic [15:0] m = 16'hACE1;

    stream_cipher_tx dut (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_val(seed_val),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .tx_valid(tx_valid), .tx_bit(tx_bit), .tx_sof(tx_sof), .tx_eof(tx_eof), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready) begin
            acc_cnt <= acc_cnt + 1;
            acc_cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && tx_valid) begin
            if (tx_sof) begin
                idx = 0;
                gap = cyc - eof_cyc;
                sof_cyc = cyc;
            end
            if (idx < 8) rx_byte[idx[2:0]] = tx_bit;
            idx++;
            if (tx_eof) eof_cyc = cyc;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL tx_extra: got bit=%b sof=%b eof=%b, required no output", tx_bit, tx_sof, tx_eof);
            end else begin
                e = q.pop_front();
                if ({tx_bit, tx_sof, tx_eof} !== e) begin
                    failures++;
                    $display("FAIL tx_stream: got bit/sof/eof=%b%b%b required %b%b%b",
                             tx_bit, tx_sof, tx_eof, e.b, e.sof, e.eof);
                end
            end
        end
    end

    function automatic logic [15:0] mstep(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic push_frame(input logic [7:0] d);
        logic p, b;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b = d[i] ^ m[0];
            p ^= b;
            q.push_back({b, i == 0, i == 7 && !PAR});
            m = mstep(m);
        end
        if (PAR) q.push_back({p, 1'b0, 1'b1});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        seed_load = 1'b0;
        in_valid = 1'b0;
        q.delete();
        m = 16'hACE1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        push_frame(d);
        in_valid = 1'b1;
        in_data = d;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_data = ~d;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((q.size() != 0 || busy) && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 100) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending bits busy=%b, required 0 and idle", q.size(), busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks += 3;
        if ({tx_valid, tx_bit, tx_sof, tx_eof, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 00000", {tx_valid, tx_bit, tx_sof, tx_eof, busy});
        end
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b required 1", in_ready);
        end
        if (dut.u_lfsr.lfsr !== 16'hACE1) begin
            failures++;
            $display("FAIL reset_lfsr: got %h required ace1", dut.u_lfsr.lfsr);
        end
    endtask

    task automatic test_basic();
        int a, t, rdy;
        send_byte(8'h00);
        a = acc_cyc;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 50);
        rdy = cyc;
        wait_drain();
        checks += 5;
        if (rx_byte !== 8'hE1) begin
            failures++;
            $display("FAIL basic_ct: got %h required e1", rx_byte);
        end
        if (dut.u_lfsr.lfsr !== 16'hC2C4) begin
            failures++;
            $display("FAIL basic_lfsr: got %h required c2c4", dut.u_lfsr.lfsr);
        end
        if (sof_cyc !== a) begin
            failures++;
            $display("FAIL basic_sof_time: got %0d required %0d", sof_cyc, a);
        end
        if (eof_cyc !== a + FL - 1) begin
            failures++;
            $display("FAIL basic_eof_time: got %0d required %0d", eof_cyc, a + FL - 1);
        end
        if (rdy !== a + FL) begin
            failures++;
            $display("FAIL basic_ready_time: got %0d required %0d", rdy, a + FL);
        end
    endtask

    task automatic test_zero_ct();
        do_reset();
        send_byte(8'hE1);
        wait_drain();
        checks++;
        if (rx_byte !== 8'h00) begin
            failures++;
            $display("FAIL zero_ct: got %h required 00", rx_byte);
        end
    endtask

    task automatic test_seed_zero();
        seed_load = 1'b1;
        seed_val = 16'h0000;
        in_valid = 1'b1;
        in_data = 8'h55;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL seed_ready: got %b required 0", in_ready);
        end
        @(posedge clk);
        #1 seed_load = 1'b0;
        in_valid = 1'b0;
        checks += 2;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL seed_priority: got busy=%b required 0", busy);
        end
        if (dut.u_lfsr.lfsr !== 16'hACE1) begin
            failures++;
            $display("FAIL seed_zero_lfsr: got %h required ace1", dut.u_lfsr.lfsr);
        end
        m = 16'hACE1;
        send_byte(8'h00);
        wait_drain();
        checks++;
        if (rx_byte !== 8'hE1) begin
            failures++;
            $display("FAIL seed_zero_ct: got %h required e1", rx_byte);
        end
        seed_load = 1'b1;
        seed_val = 16'h1234;
        @(posedge clk);
        #1 seed_load = 1'b0;
        checks++;
        if (dut.u_lfsr.lfsr !== 16'h1234) begin
            failures++;
            $display("FAIL seed_load_lfsr: got %h required 1234", dut.u_lfsr.lfsr);
        end
        m = 16'h1234;
        send_byte(8'hA7);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int c0, t;
        do_reset();
        push_frame(8'h00);
        push_frame(8'h00);
        c0 = acc_cnt;
        in_data = 8'h00;
        in_valid = 1'b1;
        t = 0;
        while (acc_cnt < c0 + 2 && t < 60) begin
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0;
        wait_drain();
        checks += 4;
        if (t >= 60) begin
            failures++;
            $display("FAIL b2b_accept: got %0d acceptances required 2", acc_cnt - c0);
        end
        if (gap !== 2) begin
            failures++;
            $display("FAIL b2b_gap: got sof-eof distance %0d required 2", gap);
        end
        if (rx_byte === 8'hE1) begin
            failures++;
            $display("FAIL b2b_keystream: got %h required not e1", rx_byte);
        end
        if (dut.u_lfsr.lfsr !== m) begin
            failures++;
            $display("FAIL b2b_lfsr: got %h required %h", dut.u_lfsr.lfsr, m);
        end
    endtask

    task automatic test_reset_mid();
        int t = 0, seen = 0;
        do_reset();
        send_byte(8'h5A);
        while (!(tx_valid && idx == 5) && t < 30) begin
            @(negedge clk);
            #1 t++;
        end
        #1 rst_n = 1'b0;
        #1;
        q.delete();
        checks++;
        if (t >= 30 || tx_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_abort: got tx_valid=%b busy=%b required 0 0", tx_valid, busy);
        end
        repeat (3) begin
            @(negedge clk);
            if (tx_valid) seen++;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        if (tx_valid) seen++;
        checks += 3;
        if (seen !== 0) begin
            failures++;
            $display("FAIL midreset_quiet: got %0d valid cycles required 0", seen);
        end
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_ready: got %b required 1", in_ready);
        end
        if (dut.u_lfsr.lfsr !== 16'hACE1) begin
            failures++;
            $display("FAIL midreset_lfsr: got %h required ace1", dut.u_lfsr.lfsr);
        end
        m = 16'hACE1;
        send_byte(8'h00);
        wait_drain();
        checks++;
        if (rx_byte !== 8'hE1) begin
            failures++;
            $display("FAIL midreset_ct: got %h required e1", rx_byte);
        end
    endtask

    task automatic test_seed_ignored();
        do_reset();
        send_byte(8'h3C);
        @(negedge clk);
        seed_val = 16'hFFFF;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        wait_drain();
        checks += 2;
        if (rx_byte !== 8'hDD) begin
            failures++;
            $display("FAIL seed_ignored_ct: got %h required dd", rx_byte);
        end
        if (dut.u_lfsr.lfsr !== 16'hC2C4) begin
            failures++;
            $display("FAIL seed_ignored_lfsr: got %h required c2c4", dut.u_lfsr.lfsr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 required earlier finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_ct();
        test_seed_zero();
        test_back_to_back();
        test_reset_mid();
        test_seed_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
